pc_conf_sequencer: RTL and testbench

- Configures and sequences an array of NUM_PC processing cells.
- Accepts a 32-bit configuration word stream (valid/ready) and assembles a CONF_WIDTH-bit configuration vector per cell.
- Once all cells are loaded: pulses the cell synchronous clear, enables the cells' elastic buffers for the execution phase, and reports completion.
- Sits between the configuration DMA/bus slave and the cell array's conf_bits_i / eb_en_i / clr_i inputs.

---
 rtl/pc_conf_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_pc_conf_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_conf_sequencer.sv
// Configuration loader and run sequencer for an array of NUM_PC processing cells.
// Optional PC_CONF_PARITY_EN: a trailing even-parity word per cell is checked, and a mismatch raises a sticky err_o.
module pc_conf_sequencer #(
    parameter int NUM_PC     = 16,
    parameter int CONF_WIDTH = 108,
    parameter int WORD_WIDTH = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic                         exec_done_i,
    input  logic [WORD_WIDTH-1:0]        conf_data_i,
    input  logic                         conf_valid_i,
    output logic                         conf_ready_o,
    output logic [NUM_PC*CONF_WIDTH-1:0] conf_bits_o,
    output logic                         clr_o,
    output logic [1:0]                   eb_en_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o
);

    localparam int WORDS_PER_PC = (CONF_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
`ifdef PC_CONF_PARITY_EN
    localparam int WORDS_TOTAL  = WORDS_PER_PC + 1;
`else
    localparam int WORDS_TOTAL  = WORDS_PER_PC;
`endif
    localparam int WORD_CNT_W   = (WORDS_TOTAL > 1) ? $clog2(WORDS_TOTAL) : 1;
    localparam int CELL_CNT_W   = (NUM_PC > 1) ? $clog2(NUM_PC) : 1;
    localparam int TOTAL_W      = NUM_PC * CONF_WIDTH;
    localparam logic [TOTAL_W-1:0] WORD_ONES = TOTAL_W'({WORD_WIDTH{1'b1}});
    localparam logic [TOTAL_W-1:0] CELL_ONES = TOTAL_W'({CONF_WIDTH{1'b1}});

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t                  state_r, state_next_s;
    logic [WORD_CNT_W-1:0]   word_r, word_next_s;
    logic [CELL_CNT_W-1:0]   cell_r, cell_next_s;
    logic [TOTAL_W-1:0]      conf_bits_r;
    logic                    conf_ready_r, clr_r, busy_r, done_r, err_r;
    logic [1:0]              eb_en_r;

    logic                    handshake_s, last_word_s, last_cell_s, data_word_s, parity_bad_s;
    logic                    wr_en_s, abort_clr_s, done_next_s, err_set_s, err_clr_s;
    logic [31:0]             cell_shift_s, word_shift_s;
    logic [TOTAL_W-1:0]      wr_mask_s, wr_data_s;

    assign handshake_s  = conf_ready_r & conf_valid_i;
    assign last_word_s  = (word_r == WORD_CNT_W'(WORDS_TOTAL - 1));
    assign last_cell_s  = (cell_r == CELL_CNT_W'(NUM_PC - 1));
    assign cell_shift_s = 32'(cell_r) * 32'(CONF_WIDTH);
    assign word_shift_s = cell_shift_s + 32'(word_r) * 32'(WORD_WIDTH);
    // The cell mask truncates the top word of each cell at CONF_WIDTH.
    assign wr_mask_s    = (WORD_ONES << word_shift_s) & (CELL_ONES << cell_shift_s);
    assign wr_data_s    = TOTAL_W'(conf_data_i) << word_shift_s;

`ifdef PC_CONF_PARITY_EN
    logic [CONF_WIDTH-1:0] cur_cell_s;

    function automatic logic even_parity(input logic [CONF_WIDTH-1:0] bits);
        return ^bits;
    endfunction

    // The slot already holds every data word when its parity word arrives.
    assign cur_cell_s   = CONF_WIDTH'(conf_bits_r >> cell_shift_s);
    assign data_word_s  = ~last_word_s;
    assign parity_bad_s = last_word_s & (conf_data_i[0] != even_parity(cur_cell_s));
`else
    assign data_word_s  = 1'b1;
    assign parity_bad_s = 1'b0;
`endif

    // Next-state, counter and write-enable decode.
    always_comb begin
        state_next_s = state_r;
        word_next_s  = word_r;
        cell_next_s  = cell_r;
        wr_en_s      = 1'b0;
        abort_clr_s  = 1'b0;
        done_next_s  = 1'b0;
        err_set_s    = 1'b0;
        err_clr_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (abort_i) begin
                    state_next_s = ST_IDLE;
                end else if (start_i) begin
                    state_next_s = ST_LOAD;
                    word_next_s  = '0;
                    cell_next_s  = '0;
                    err_clr_s    = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort_i) begin
                    state_next_s = ST_IDLE;
                    abort_clr_s  = 1'b1;
                end else if (handshake_s) begin
                    wr_en_s = data_word_s;
                    if (!last_word_s) begin
                        word_next_s = word_r + WORD_CNT_W'(1);
                    end else if (parity_bad_s) begin
                        state_next_s = ST_IDLE;
                        err_set_s    = 1'b1;
                        word_next_s  = '0;
                    end else if (last_cell_s) begin
                        state_next_s = ST_CLEAR;
                        word_next_s  = '0;
                        cell_next_s  = '0;
                    end else begin
                        word_next_s = '0;
                        cell_next_s = cell_r + CELL_CNT_W'(1);
                    end
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_CLEAR: begin
                if (abort_i) begin
                    state_next_s = ST_IDLE;
                    abort_clr_s  = 1'b1;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_i) begin
                    state_next_s = ST_IDLE;
                    abort_clr_s  = 1'b1;
                end else if (exec_done_i) begin
                    state_next_s = ST_IDLE;
                    done_next_s  = 1'b1;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, counters, configuration store and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= ST_IDLE;
            word_r       <= '0;
            cell_r       <= '0;
            conf_bits_r  <= '0;
            conf_ready_r <= 1'b0;
            clr_r        <= 1'b0;
            eb_en_r      <= 2'b00;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            word_r       <= word_next_s;
            cell_r       <= cell_next_s;
            if (wr_en_s) begin
                conf_bits_r <= (conf_bits_r & ~wr_mask_s) | (wr_data_s & wr_mask_s);
            end
            conf_ready_r <= (state_next_s == ST_LOAD);
            clr_r        <= abort_clr_s | (state_next_s == ST_CLEAR);
            eb_en_r      <= (state_next_s == ST_RUN) ? 2'b11 : 2'b00;
            busy_r       <= (state_next_s != ST_IDLE);
            done_r       <= done_next_s;
            if (err_set_s) begin
                err_r <= 1'b1;
            end else if (err_clr_s) begin
                err_r <= 1'b0;
            end
        end
    end

    assign conf_ready_o = conf_ready_r;
    assign conf_bits_o  = conf_bits_r;
    assign clr_o        = clr_r;
    assign eb_en_o      = eb_en_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign err_o        = err_r;

endmodule

// File: tb/tb_pc_conf_sequencer.sv
// Scoreboard bench for pc_conf_sequencer: a word-stream model predicts clear/run/done/abort events and the loaded bits.
module tb_pc_conf_sequencer;

    localparam int NPC = 2;
    localparam int CW  = 108;
    localparam int WW  = 32;
    localparam int WPP = 4;
`ifdef PC_CONF_PARITY_EN
    localparam int WPC = WPP + 1;
`else
    localparam int WPC = WPP;
`endif
    localparam int TW = NPC * CW;
    localparam int K_CLEAR = 1, K_RUN = 2, K_DONE = 3, K_ABORT = 4, K_PERR = 5;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, exec_done = 1'b0;
    logic [WW-1:0] conf_data = '0;
    logic          conf_valid = 1'b0;
    logic          conf_ready, clr, busy, done, err;
    logic [TW-1:0] conf_bits;
    logic [1:0]    eb_en;

    typedef struct {
        int            kind;
        int            cyc;
        logic [TW-1:0] bits;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          mon_e;
    logic [CW-1:0] model[NPC];
    int            cyc = 0, total = 0, passed = 0, obs_k = 0;
    bit            prev_eb = 1'b0, prev_err = 1'b0;

    pc_conf_sequencer #(.NUM_PC(NPC), .CONF_WIDTH(CW), .WORD_WIDTH(WW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .exec_done_i(exec_done),
        .conf_data_i(conf_data), .conf_valid_i(conf_valid), .conf_ready_o(conf_ready),
        .conf_bits_o(conf_bits), .clr_o(clr), .eb_en_o(eb_en), .busy_o(busy), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [TW-1:0] model_flat();
        logic [TW-1:0] f;
        for (int p = 0; p < NPC; p++) f[p*CW +: CW] = model[p];
        return f;
    endfunction

    // Word w of a cell lands at bit offset w*32; bits beyond the cell width are dropped.
    task automatic model_write(input int c, input int w, input logic [31:0] d);
        for (int b = 0; b < WW; b++)
            if (w * WW + b < CW) model[c][w*WW+b] = d[b];
    endtask

    task automatic expect_ev(input int kind, input int at);
        exp_t e;
        e.kind = kind;
        e.cyc  = at;
        e.bits = model_flat();
        sb_q.push_back(e);
    endtask

    // Monitor: classify each output event and compare it with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            obs_k = 0;
            if (done) obs_k = K_DONE;
            else if (clr) obs_k = busy ? K_CLEAR : K_ABORT;
            else if (eb_en == 2'b11 && !prev_eb) obs_k = K_RUN;
            else if (err && !prev_err) obs_k = K_PERR;
            if (obs_k != 0) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_event", obs_k, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("event_kind", obs_k, mon_e.kind);
                    chk("event_cycle", cyc, mon_e.cyc);
                    chk("conf_bits", conf_bits, mon_e.bits);
                    chk("eb_en", eb_en, (mon_e.kind == K_RUN) ? 2'b11 : 2'b00);
                    chk("busy", busy, (mon_e.kind == K_RUN || mon_e.kind == K_CLEAR));
                    chk("err", err, (mon_e.kind == K_PERR));
                end
            end
            prev_eb  = (eb_en == 2'b11);
            prev_err = err;
        end else begin
            prev_eb  = 1'b0;
            prev_err = 1'b0;
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input bit stall, input bit ab, output int hs);
        @(negedge clk);
        if (stall) begin
            chk("ready_during_stall", conf_ready, 1'b1);
            @(negedge clk);
        end
        chk("ready_in_load", conf_ready, 1'b1);
        conf_data  = d;
        conf_valid = 1'b1;
        abort      = ab;
        hs         = cyc;
        @(posedge clk);
        #1 conf_valid = 1'b0;
        abort = 1'b0;
    endtask

    // mode 0: continuous valid, 1: valid every other cycle, 2: random stalls.
    task automatic load_seq(input int mode, input int abort_at, input bit fixed);
        int hs, dk, k;
        bit stall;
        logic [31:0] d;
        dk = 0;
        k  = 0;
        do_start();
        chk("err_cleared_on_start", err, 1'b0);
        for (int c = 0; c < NPC; c++) begin
            for (int w = 0; w < WPC; w++) begin
                if (w < WPP) begin
                    d = fixed ? 32'h11111111 * (dk + 1) : $urandom();
                end else begin
                    d = $urandom();
                    d[0] = ^model[c];
                end
                stall = (mode == 1) || (mode == 2 && $urandom_range(0, 1) == 1);
                send_word(d, stall, k == abort_at, hs);
                if (k == abort_at) begin
                    expect_ev(K_ABORT, hs + 1);
                    return;
                end
                if (w < WPP) begin
                    model_write(c, w, d);
                    dk++;
                end
                k++;
            end
        end
        expect_ev(K_CLEAR, hs + 1);
        expect_ev(K_RUN, hs + 2);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("events_drained", sb_q.size(), 0);
    endtask

    task automatic finish_run(input int wait_cycles);
        repeat (wait_cycles) @(negedge clk);
        @(negedge clk);
        exec_done = 1'b1;
        expect_ev(K_DONE, cyc + 1);
        @(posedge clk);
        #1 exec_done = 1'b0;
        wait_drain();
        @(negedge clk);
        #1;
        chk("done_single_cycle", done, 1'b0);
        chk("idle_after_done", busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        for (int p = 0; p < NPC; p++) model[p] = '0;
        #2;
        chk("rst_conf_bits", conf_bits, 0);
        chk("rst_clr", clr, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", conf_ready, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_eb_en", eb_en, 2'b00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        load_seq(0, -1, 1'b1);
        wait_drain();
        finish_run(2);

        load_seq(1, -1, 1'b1);
        wait_drain();
        finish_run(0);

        for (int r = 0; r < 3; r++) begin
            load_seq(2, -1, 1'b0);
            wait_drain();
            finish_run($urandom_range(0, 5));
        end

        // Abort on the third handshake, then a fresh load from cell 0 word 0.
        load_seq(0, 2, 1'b0);
        wait_drain();
        load_seq(2, -1, 1'b0);
        wait_drain();
        @(negedge clk);
        abort     = 1'b1;
        exec_done = 1'b1;
        expect_ev(K_ABORT, cyc + 1);
        @(posedge clk);
        #1 abort = 1'b0;
        exec_done = 1'b0;
        wait_drain();

        // abort in IDLE, alone and together with start.
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_no_clr", clr, 1'b0);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("start_abort_busy", busy, 1'b0);
        chk("start_abort_ready", conf_ready, 1'b0);

`ifdef PC_CONF_PARITY_EN
        do_start();
        for (int w = 0; w < WPP; w++) begin
            send_word((w == 0) ? 32'h1 : 32'h0, 1'b0, 1'b0, hs);
            model_write(0, w, (w == 0) ? 32'h1 : 32'h0);
        end
        send_word(32'h0, 1'b0, 1'b0, hs);
        expect_ev(K_PERR, hs + 1);
        wait_drain();
        repeat (3) @(negedge clk);
        chk("parity_err_sticky", err, 1'b1);
        chk("parity_err_idle", busy, 1'b0);
        load_seq(0, -1, 1'b0);
        wait_drain();
        finish_run(1);
`endif

        // Asynchronous reset in the middle of RUN.
        load_seq(2, -1, 1'b0);
        wait_drain();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_eb_en", eb_en, 2'b00);
        chk("async_rst_conf_bits", conf_bits, 0);
        chk("async_rst_busy", busy, 1'b0);
        for (int p = 0; p < NPC; p++) model[p] = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", busy, 1'b0);
        chk("post_rst_ready", conf_ready, 1'b0);
        load_seq(0, -1, 1'b0);
        wait_drain();
        finish_run(1);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
